dma_desc_sched: RTL

DMA_DESC_SCHED -- requirements
Module: dma_desc_sched

---
 rtl/dma_pkg.sv | 36 +++
 rtl/desc_fifo.sv | 97 +++++++++
 rtl/dma_desc_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA descriptor scheduler:
//   - BURST_W / LEN_W : descriptor burst and byte-length field widths
//   - sched_state_t   : scheduler FSM encoding (IDLE, LAUNCH, RUN, ERR)
//   - desc_attr_t     : address-independent descriptor fields
//   - is_zero_len()   : a zero-length descriptor completes without a launch
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam int BURST_W = 4;
  localparam int LEN_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_ERR    = 2'd3
  } sched_state_t;

  // The address is kept outside the struct because its width is a module
  // parameter. A package struct cannot depend on that parameter.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic               dir;
    logic               incr;
    logic [BURST_W-1:0] burst;
  } desc_attr_t;

  localparam int ATTR_W = $bits(desc_attr_t);

  function automatic logic is_zero_len(input desc_attr_t attr);
    return (attr.len == '0);
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// ---------------------------------------------------------------------------
// desc_fifo
// DEPTH-entry descriptor FIFO holding {addr, len, dir, incr, burst}.
// The head entry is read combinationally, so the scheduler can inspect it in
// the same cycle it decides to launch or skip it.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   i_push, i_addr,      write one descriptor (ignored while full)
//   i_attr
//   i_pop                drop the head entry (ignored while empty)
//   i_flush              empty the queue
//   i_flush_keep_head    drop everything except the head entry
//   o_head_addr/attr     current head entry
//   o_level              number of stored entries
//   o_full, o_empty      status flags
// Both flush requests take priority over a push or pop in the same cycle.
// ---------------------------------------------------------------------------
module desc_fifo
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_push,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  desc_attr_t              i_attr,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic                    i_flush_keep_head,
  output logic [ADDR_WIDTH-1:0]   o_head_addr,
  output desc_attr_t              o_head_attr,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int DATA_W = ADDR_WIDTH + ATTR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic w_any_flush;
  logic w_do_push;
  logic w_do_pop;

  assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_level     = r_count;
  assign w_any_flush = i_flush || i_flush_keep_head;
  assign w_do_push   = i_push && !o_full  && !w_any_flush;
  assign w_do_pop    = i_pop  && !o_empty && !w_any_flush;

  assign {o_head_addr, o_head_attr} = r_mem[r_rd_ptr];

  // Storage is not reset; only the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= {i_addr, i_attr};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush_keep_head) begin
      // Rewind the write pointer to just behind the head entry.
      if (!o_empty) begin
        r_wr_ptr <= r_rd_ptr + 1'b1;
        r_count  <= (PTR_W+1)'(1);
      end
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dma_desc_sched.sv
// ---------------------------------------------------------------------------
// dma_desc_sched
// Queues DMA descriptors and launches them one at a time on a DMA engine.
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   desc_valid_i/desc_ready_o    descriptor push handshake
//   desc_addr_i, desc_len_i,     descriptor fields
//   desc_dir_i, desc_incr_i,
//   desc_burst_i
//   run_i                        level; permits new launches
//   abort_i                      pulse; drop queued entries not in flight
//   err_clr_i                    pulse; leave the error state
//   irq_ack_i                    pulse; clear the completion interrupt
//   dma_en_o                     one-cycle engine start pulse
//   dma_dir_o .. dma_len_o       engine configuration, held between launches
//   dma_done_i/err_i/busy_i      engine status
//   q_level_o                    queued descriptors, including the in-flight one
//   done_cnt_o                   completed-descriptor count (wraps)
//   irq_o, err_o, idle_o         completion irq, sticky error, idle
// The in-flight descriptor stays at the FIFO head until its done pulse, so
// the queue level counts it and an abort can keep it while flushing the rest.
// ---------------------------------------------------------------------------
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [ADDR_WIDTH-1:0]   desc_addr_i,
  input  logic [LEN_W-1:0]        desc_len_i,
  input  logic                    desc_dir_i,
  input  logic                    desc_incr_i,
  input  logic [BURST_W-1:0]      desc_burst_i,
  input  logic                    run_i,
  input  logic                    abort_i,
  input  logic                    err_clr_i,
  input  logic                    irq_ack_i,
  output logic                    dma_en_o,
  output logic                    dma_dir_o,
  output logic                    dma_incr_o,
  output logic [BURST_W-1:0]      dma_burst_o,
  output logic [ADDR_WIDTH-1:0]   dma_addr_o,
  output logic [LEN_W-1:0]        dma_len_o,
  input  logic                    dma_done_i,
  input  logic                    dma_err_i,
  input  logic                    dma_busy_i,
  output logic [$clog2(DEPTH):0]  q_level_o,
  output logic [CNT_WIDTH-1:0]    done_cnt_o,
  output logic                    irq_o,
  output logic                    err_o,
  output logic                    idle_o
);

  sched_state_t          r_state;
  sched_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_dma_addr;
  logic [LEN_W-1:0]      r_dma_len;
  logic                  r_dma_dir;
  logic                  r_dma_incr;
  logic [BURST_W-1:0]    r_dma_burst;
  logic [CNT_WIDTH-1:0]  r_done_cnt;
  logic                  r_irq;
  logic                  r_err;

  logic                  w_push;
  desc_attr_t            w_push_attr;
  logic                  w_pop;
  logic                  w_flush_all;
  logic                  w_flush_keep_head;
  logic                  w_load_cfg;
  logic                  w_done_inc;
  logic                  w_err_set;
  logic                  w_err_clr;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  desc_attr_t            w_head_attr;
  logic                  w_full;
  logic                  w_empty;

  // Held low while in reset so no descriptor can be accepted then.
  assign desc_ready_o = resetn && !w_full && !r_err;
  assign w_push       = desc_valid_i && desc_ready_o;

  assign w_push_attr.len   = desc_len_i;
  assign w_push_attr.dir   = desc_dir_i;
  assign w_push_attr.incr  = desc_incr_i;
  assign w_push_attr.burst = desc_burst_i;

  desc_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk               (clk),
    .resetn            (resetn),
    .i_push            (w_push),
    .i_addr            (desc_addr_i),
    .i_attr            (w_push_attr),
    .i_pop             (w_pop),
    .i_flush           (w_flush_all),
    .i_flush_keep_head (w_flush_keep_head),
    .o_head_addr       (w_head_addr),
    .o_head_attr       (w_head_attr),
    .o_level           (q_level_o),
    .o_full            (w_full),
    .o_empty           (w_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pop             = 1'b0;
    w_flush_all       = 1'b0;
    w_flush_keep_head = 1'b0;
    w_load_cfg        = 1'b0;
    w_done_inc        = 1'b0;
    w_err_set         = 1'b0;
    w_err_clr         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run_i && !w_empty) begin
          if (is_zero_len(w_head_attr)) begin
            // Nothing to transfer: retire it directly as a completion.
            w_pop      = 1'b1;
            w_done_inc = 1'b1;
          end else if (!dma_busy_i) begin
            w_load_cfg   = 1'b1;
            w_state_next = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (dma_done_i) begin
          w_pop        = 1'b1;
          w_done_inc   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (err_clr_i) begin
          w_err_clr    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // The head is in flight if it is launching now or already running. If it
    // is also retiring this cycle, nothing needs to be kept.
    if (abort_i) begin
      if ((w_load_cfg || r_state == ST_LAUNCH || r_state == ST_RUN) && !w_pop) begin
        w_flush_keep_head = 1'b1;
      end else begin
        w_flush_all = 1'b1;
      end
    end

    // An engine error overrides everything, including a coincident done.
    if (dma_err_i && r_state != ST_ERR) begin
      w_state_next      = ST_ERR;
      w_err_set         = 1'b1;
      w_flush_all       = 1'b1;
      w_flush_keep_head = 1'b0;
      w_pop             = 1'b0;
      w_done_inc        = 1'b0;
      w_load_cfg        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dma_addr  <= '0;
      r_dma_len   <= '0;
      r_dma_dir   <= 1'b0;
      r_dma_incr  <= 1'b0;
      r_dma_burst <= '0;
    end else if (w_load_cfg) begin
      r_dma_addr  <= w_head_addr;
      r_dma_len   <= w_head_attr.len;
      r_dma_dir   <= w_head_attr.dir;
      r_dma_incr  <= w_head_attr.incr;
      r_dma_burst <= w_head_attr.burst;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done_cnt <= '0;
      r_irq      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_done_inc) begin
        r_done_cnt <= r_done_cnt + 1'b1;
      end
      // A new completion beats a coincident acknowledge.
      if (w_done_inc) begin
        r_irq <= 1'b1;
      end else if (irq_ack_i) begin
        r_irq <= 1'b0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign dma_en_o    = (r_state == ST_LAUNCH);
  assign dma_addr_o  = r_dma_addr;
  assign dma_len_o   = r_dma_len;
  assign dma_dir_o   = r_dma_dir;
  assign dma_incr_o  = r_dma_incr;
  assign dma_burst_o = r_dma_burst;
  assign done_cnt_o  = r_done_cnt;
  assign irq_o       = r_irq;
  assign err_o       = r_err;
  assign idle_o      = (r_state == ST_IDLE) && w_empty;

endmodule
